cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss handler that sits between the data/instruction cache and multi-cycle main memory. On a miss it issues a burst of word reads for the whole cache block, then streams returned words into the cache data array. It finishes with a one-cycle tag/meta write, which makes the next lookup hit. It drives the cache's data-write and tag-write enables and the fill address; the cache's stall output is its trigger.

## Interface
- ADDR_WIDTH, 16, byte address width
- BLOCK_WORDS, 8, 16-bit words per block; power of two, 2..8; block = 2*BLOCK_WORDS bytes
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- miss_detected  in  1  cache miss (cache stall output); level-sensitive
- miss_address  in  ADDR_WIDTH  byte address of the missing access
- memory_data_valid  in  1  memory returns one word this cycle
- memory_data  in  16  returned word, qualified by memory_data_valid
- fsm_busy  out  1  fill in progress; holds the pipeline stalled
- mem_read_en  out  1  read request to memory this cycle
- memory_address  out  ADDR_WIDTH  request address, word-aligned
- write_data_array  out  1  write one word into the cache data array
- write_tag_array  out  1  write tag/valid/LRU into the meta array
- cache_addr  out  ADDR_WIDTH  address presented to the cache for the current write
- cache_data  out  16  word to write; equals memory_data

## Operation
- Offset bits: OB = log2(2*BLOCK_WORDS), which is 4 at the defaults. base = {latched_addr[ADDR_WIDTH-1:OB], OB'b0}.
- States:
  - IDLE: all outputs 0.
  - FILL: request and receive phase.
  - TAG: one cycle.
- IDLE -> FILL:
  - On a clk edge with miss_detected=1 and rst=0.
  - latched_addr <= miss_address.
  - issue_cnt <= 0; recv_cnt <= 0.
- FILL request side:
  - mem_read_en=1 while issue_cnt < BLOCK_WORDS.
  - memory_address = base + 2*issue_cnt.
  - issue_cnt increments each cycle with mem_read_en=1 and saturates at BLOCK_WORDS.
- FILL receive side:
  - write_data_array = memory_data_valid.
  - cache_addr = base + 2*recv_cnt.
  - recv_cnt increments on each valid word.
  - The receive side runs independently of the request side; a response may arrive while requests are still being issued.
  - Gaps between valid words are allowed.
- FILL -> TAG: on the edge that accepts word BLOCK_WORDS-1 (recv_cnt = BLOCK_WORDS-1 with valid).
- TAG:
  - write_tag_array=1, write_data_array=0, mem_read_en=0.
  - cache_addr = latched_addr, so the cache computes tag and index from the original address.
- TAG -> IDLE: unconditionally after one cycle.
- fsm_busy = (state != IDLE), including the TAG cycle.
- Ignored inputs:
  - miss_detected while busy.
  - memory_data_valid in IDLE or TAG.
  - Changes of miss_address after latch.
- Counters are log2(BLOCK_WORDS)+1 bits wide. Address arithmetic is ADDR_WIDTH wide with no carry out of the offset field; base alignment guarantees this.

## Timing
- Reset (rst=1 at an edge) gives state IDLE and zeroes counters and latched_addr. All outputs are 0 the following cycle: fsm_busy, mem_read_en, memory_address, write_data_array, write_tag_array, cache_addr. cache_data follows memory_data.
- Reset in mid-fill aborts the fill and performs no tag write. Memory is reset by the same rst, so no stale responses follow.
- Outputs derive combinationally from state registers, counters and memory_data_valid only. No combinational path from miss_detected.
- Cycle numbering: cycle k is the cycle after the k-th rising edge following the miss sample; the sampling edge is edge 0.
- With a memory of fixed latency L (valid L cycles after the request):
  - Requests occur in cycles 1..BLOCK_WORDS.
  - Data writes occur in cycles 1+L..BLOCK_WORDS+L.
  - TAG occurs in cycle BLOCK_WORDS+L+1.
  - fsm_busy=0 from cycle BLOCK_WORDS+L+2.
- If miss_detected is still high in the first IDLE cycle, a new fill starts. The cache normally hits by then, so this does not occur in practice.
- Back-to-back misses therefore have a minimum of one IDLE cycle between fills.

## Test plan
- Basic fill (defaults, L=4, miss_address=0x1234):
  - memory_address = 0x1230,0x1232,…,0x123E in cycles 1–8.
  - write_data_array in cycles 5–12, with cache_addr 0x1230..0x123E and data 0..7.
  - write_tag_array with cache_addr=0x1234 in cycle 13; fsm_busy=0 in cycle 14.
- Irregular returns: data_valid pattern 1,0,0,1,1,0,1,1,1,0,1,1 -> exactly 8 writes to consecutive cache_addr values, and TAG one cycle after the 8th.
- Miss while busy: miss_address changes to 0x5432 and miss_detected stays high during the fill of 0x1234 -> no effect; the tag write uses 0x1234. Next fill base is 0x5430.
- Spurious valid: memory_data_valid=1 in IDLE and during TAG -> no write_data_array, counters unchanged.
- Reset mid-fill: rst asserted after the 3rd data write -> next cycle all outputs 0, with no tag write. A subsequent miss at 0x1a34 fills 0x1a30..0x1a3E from word 0.
- BLOCK_WORDS=4, miss 0x00FF: requests 0x00F8,0x00FA,0x00FC,0x00FE; tag write with cache_addr=0x00FF.

Source files
------------

// File: rtl/cache_fill_fsm_if.sv
// rtl/cache_fill_fsm_if.sv - miss trigger, memory read port and cache write port of the fill FSM
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  logic                  fsm_busy;
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [15:0]           cache_data;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address,
    output write_data_array, write_tag_array, cache_addr, cache_data
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address,
    input  write_data_array, write_tag_array, cache_addr, cache_data
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss handler: burst-reads a block, streams it into the data array, then writes the tag
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus
);
  localparam int OB = $clog2(2 * BLOCK_WORDS);
  localparam int CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CW-1:0] FULL = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         issue_cnt, recv_cnt;
  logic [ADDR_WIDTH-1:0] latched_addr;
  logic [ADDR_WIDTH-1:0] base, issue_addr, recv_addr;

  logic                  busy, rd_en, wr_data, wr_tag;
  logic [ADDR_WIDTH-1:0] mem_addr, c_addr;

  // Block alignment keeps word offsets inside the offset field, so no carry into the index.
  assign base       = {latched_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
  assign issue_addr = base + (ADDR_WIDTH'(issue_cnt) << 1);
  assign recv_addr  = base + (ADDR_WIDTH'(recv_cnt) << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      latched_addr <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            latched_addr <= bus.miss_address;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
          end
        end
        FILL: begin
          if (rd_en)                 issue_cnt <= issue_cnt + CW'(1);
          if (bus.memory_data_valid) recv_cnt  <= recv_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    rd_en      = 1'b0;
    wr_data    = 1'b0;
    wr_tag     = 1'b0;
    mem_addr   = '0;
    c_addr     = '0;
    case (state)
      IDLE: begin
        if (bus.miss_detected) state_next = FILL;
      end
      FILL: begin
        // Request and receive sides advance independently; only the last received word ends the fill.
        busy     = 1'b1;
        rd_en    = (issue_cnt < FULL);
        mem_addr = issue_addr;
        wr_data  = bus.memory_data_valid;
        c_addr   = recv_addr;
        if (bus.memory_data_valid && (recv_cnt == LAST)) state_next = TAG;
      end
      TAG: begin
        busy       = 1'b1;
        wr_tag     = 1'b1;
        c_addr     = latched_addr;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.fsm_busy         = busy;
  assign bus.mem_read_en      = rd_en;
  assign bus.memory_address   = mem_addr;
  assign bus.write_data_array = wr_data;
  assign bus.write_tag_array  = wr_tag;
  assign bus.cache_addr       = c_addr;
  assign bus.cache_data       = bus.memory_data;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed per-cycle vector bench for cache_fill_fsm
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst;
  logic rst4;

  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_WIDTH(16)) bus ();
  cache_fill_fsm_if #(.ADDR_WIDTH(16)) bus4 ();

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(4)) dut4 (
    .clk(clk),
    .rst(rst4),
    .bus(bus4)
  );

  typedef struct {
    logic        rst;
    logic        miss;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] data;
    logic        busy;
    logic        rd;
    logic [15:0] maddr;
    logic        wd;
    logic        wt;
    logic [15:0] caddr;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic m, input logic [15:0] a, input logic vl,
                     input logic [15:0] d, input logic b, input logic rd, input logic [15:0] ma,
                     input logic wd, input logic wt, input logic [15:0] ca);
    vec_t v;
    v.rst = r; v.miss = m; v.addr = a; v.valid = vl; v.data = d;
    v.busy = b; v.rd = rd; v.maddr = ma; v.wd = wd; v.wt = wt; v.caddr = ca;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input logic m, input logic [15:0] a, input logic vl, input logic [15:0] d);
    add(1'b0, m, a, vl, d, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  // Fill of 0x1234 with fixed latency 4; miss/address held at the given values while busy
  task automatic add_fill_1234(input logic m_busy, input logic [15:0] a_busy);
    add_idle(1'b1, 16'h1234, 1'b0, 16'h0);
    for (int k = 1; k <= 12; k++) begin
      logic vl;
      logic rd;
      int   rc;
      vl = (k >= 5);
      rd = (k <= 8);
      rc = (k < 5) ? 0 : k - 5;
      add(1'b0, m_busy, a_busy, vl, 16'(k - 5), 1'b1, rd,
          rd ? 16'(16'h1230 + 2 * (k - 1)) : 16'h0, vl, 1'b0, 16'(16'h1230 + 2 * rc));
    end
    add(1'b0, m_busy, a_busy, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1234);
  endtask

  initial begin
    logic [11:0] pat;
    int          r;

    // Reset state and spurious valid in IDLE
    add_idle(1'b0, 16'h0, 1'b1, 16'hbeef);
    add_idle(1'b0, 16'h0, 1'b1, 16'hbeef);
    add_idle(1'b0, 16'h0, 1'b0, 16'h0);

    // Basic fill
    add_fill_1234(1'b0, 16'h1234);
    add_idle(1'b0, 16'h1234, 1'b0, 16'h0);

    // Irregular returns, then spurious valid in TAG and IDLE
    pat = 12'b110111011001;
    r   = 0;
    add_idle(1'b1, 16'h2468, 1'b0, 16'h0);
    for (int k = 1; k <= 12; k++) begin
      logic vl;
      logic rd;
      vl = pat[k - 1];
      rd = (k <= 8);
      add(1'b0, 1'b0, 16'h2468, vl, 16'(16'h100 + r), 1'b1, rd,
          rd ? 16'(16'h2460 + 2 * (k - 1)) : 16'h0, vl, 1'b0, 16'(16'h2460 + 2 * r));
      if (vl) r++;
    end
    add(1'b0, 1'b0, 16'h2468, 1'b1, 16'hdead, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2468);
    add_idle(1'b0, 16'h2468, 1'b1, 16'hdead);

    // Miss while busy with changing address, then back-to-back fill of 0x5432
    add_fill_1234(1'b1, 16'h5432);
    add_idle(1'b1, 16'h5432, 1'b0, 16'h0);
    for (int j = 0; j < 8; j++)
      add(1'b0, 1'b0, 16'h5432, 1'b1, 16'(16'h50 + j), 1'b1, 1'b1, 16'(16'h5430 + 2 * j),
          1'b1, 1'b0, 16'(16'h5430 + 2 * j));
    add(1'b0, 1'b0, 16'h5432, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h5432);
    add_idle(1'b0, 16'h5432, 1'b0, 16'h0);

    // Reset after the third data write, then a fresh fill of 0x1a34
    add_idle(1'b1, 16'h1234, 1'b0, 16'h0);
    for (int k = 1; k <= 7; k++) begin
      logic vl;
      vl = (k >= 5);
      add(1'b0, 1'b0, 16'h1234, vl, 16'(k - 5), 1'b1, 1'b1, 16'(16'h1230 + 2 * (k - 1)),
          vl, 1'b0, 16'(16'h1230 + 2 * ((k < 5) ? 0 : k - 5)));
    end
    add(1'b1, 1'b0, 16'h1234, 1'b0, 16'h0, 1'b1, 1'b1, 16'h123e, 1'b0, 1'b0, 16'h1236);
    add_idle(1'b1, 16'h1a34, 1'b0, 16'h0);
    for (int j = 0; j < 8; j++)
      add(1'b0, 1'b0, 16'h1a34, 1'b1, 16'(16'ha0 + j), 1'b1, 1'b1, 16'(16'h1a30 + 2 * j),
          1'b1, 1'b0, 16'(16'h1a30 + 2 * j));
    add(1'b0, 1'b0, 16'h1a34, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1a34);
    add_idle(1'b0, 16'h1a34, 1'b0, 16'h0);

    rst  = 1'b1;
    rst4 = 1'b1;
    bus.miss_detected      = 1'b0;
    bus.miss_address       = 16'h0;
    bus.memory_data_valid  = 1'b0;
    bus.memory_data        = 16'h0;
    bus4.miss_detected     = 1'b0;
    bus4.miss_address      = 16'h0;
    bus4.memory_data_valid = 1'b0;
    bus4.memory_data       = 16'h0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst                   = vecs[i].rst;
      bus.miss_detected     = vecs[i].miss;
      bus.miss_address      = vecs[i].addr;
      bus.memory_data_valid = vecs[i].valid;
      bus.memory_data       = vecs[i].data;
      @(negedge clk);
      chk($sformatf("v%0d busy", i), 16'(bus.fsm_busy), 16'(vecs[i].busy));
      chk($sformatf("v%0d mem_read_en", i), 16'(bus.mem_read_en), 16'(vecs[i].rd));
      if (vecs[i].rd || !vecs[i].busy)
        chk($sformatf("v%0d memory_address", i), bus.memory_address, vecs[i].maddr);
      chk($sformatf("v%0d write_data_array", i), 16'(bus.write_data_array), 16'(vecs[i].wd));
      chk($sformatf("v%0d write_tag_array", i), 16'(bus.write_tag_array), 16'(vecs[i].wt));
      chk($sformatf("v%0d cache_addr", i), bus.cache_addr, vecs[i].caddr);
      if (vecs[i].wd)
        chk($sformatf("v%0d cache_data", i), bus.cache_data, vecs[i].data);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // BLOCK_WORDS=4 at an unaligned address near the top of its block
    rst4               = 1'b0;
    bus4.miss_detected = 1'b1;
    bus4.miss_address  = 16'h00ff;
    @(negedge clk);
    chk("bw4 c0 busy", 16'(bus4.fsm_busy), 16'h0);
    @(posedge clk);
    #1;
    bus4.miss_detected = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus4.memory_data_valid = 1'b1;
      bus4.memory_data       = 16'(16'h40 + j);
      @(negedge clk);
      chk($sformatf("bw4 c%0d mem_read_en", j + 1), 16'(bus4.mem_read_en), 16'h1);
      chk($sformatf("bw4 c%0d memory_address", j + 1), bus4.memory_address, 16'(16'h00f8 + 2 * j));
      chk($sformatf("bw4 c%0d write_data_array", j + 1), 16'(bus4.write_data_array), 16'h1);
      chk($sformatf("bw4 c%0d cache_addr", j + 1), bus4.cache_addr, 16'(16'h00f8 + 2 * j));
      @(posedge clk);
      #1;
    end
    bus4.memory_data_valid = 1'b0;
    @(negedge clk);
    chk("bw4 tag write_tag_array", 16'(bus4.write_tag_array), 16'h1);
    chk("bw4 tag cache_addr", bus4.cache_addr, 16'h00ff);
    chk("bw4 tag mem_read_en", 16'(bus4.mem_read_en), 16'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bw4 done busy", 16'(bus4.fsm_busy), 16'h0);
    chk("bw4 done write_tag_array", 16'(bus4.write_tag_array), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
